// File: rtl/dcpu_pkg.sv
// Shared types and constants for the CPU/device RAM arbiter.
// State, owner encodings and the saturating counter helper live here.
package dcpu_pkg;

    localparam int RAM_ADDR_W = 16;
    localparam int RAM_DATA_W = 16;
    localparam int CNT_W      = 4;

    typedef enum logic {
        S_cpu,
        S_dev_burst
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DEV
    } owner_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dcpu_ram_rdreturn.sv
// Read-return path: remembers who owns the outstanding read and steers
// the RAM output into that requester's data register with a one-cycle valid.
module dcpu_ram_rdreturn
    import dcpu_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              srst,
    input  owner_t            rd_owner_i,
    input  logic [DATA_W-1:0] ram_q_i,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              dev_rvalid_o,
    output logic [DATA_W-1:0] dev_rdata_o
);

    owner_t            rd_tag_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dev_rdata_q;

    // The RAM clocks on the rising edge inside the grant cycle, so at the
    // closing falling edge ram_q_i already holds the word for the granted read.
    always_ff @(negedge clk) begin
        if (srst) begin
            rd_tag_q    <= OWN_NONE;
            cpu_rdata_q <= '0;
            dev_rdata_q <= '0;
        end else begin
            rd_tag_q <= rd_owner_i;
            if (rd_owner_i == OWN_CPU) begin
                cpu_rdata_q <= ram_q_i;
            end
            if (rd_owner_i == OWN_DEV) begin
                dev_rdata_q <= ram_q_i;
            end
        end
    end

    assign cpu_rvalid_o = (rd_tag_q == OWN_CPU);
    assign dev_rvalid_o = (rd_tag_q == OWN_DEV);
    assign cpu_rdata_o  = cpu_rdata_q;
    assign dev_rdata_o  = dev_rdata_q;

endmodule

// File: rtl/dcpu_ram_arbiter.sv
// Single-port RAM arbiter: CPU has priority, the device gets a guaranteed
// slot after MAX_WAIT refusals and may lock the port for up to BURST_MAX grants.
module dcpu_ram_arbiter
    import dcpu_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              CORE_CLK,
    input  logic              RESET,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dev_req,
    input  logic [ADDR_W-1:0] dev_addr,
    input  logic [DATA_W-1:0] dev_wdata,
    input  logic              dev_wr,
    input  logic              dev_lock,
    output logic              dev_gnt,
    output logic              dev_rvalid,
    output logic [DATA_W-1:0] dev_rdata,
    output logic [ADDR_W-1:0] RAM_addr,
    output logic [DATA_W-1:0] RAM_data,
    output logic              RAM_wr,
    input  logic [DATA_W-1:0] RAM_q
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    owner_t           rd_owner;

    always_comb begin
        cpu_gnt     = 1'b0;
        dev_gnt     = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_cpu: begin
                if (cpu_req && !(dev_req && wait_cnt_q == MAX_WAIT_C)) begin
                    cpu_gnt = 1'b1;
                end else if (dev_req) begin
                    dev_gnt = 1'b1;
                end
                if (dev_req && !dev_gnt) begin
                    wait_cnt_d = sat_inc(wait_cnt_q, MAX_WAIT_C);
                end else begin
                    wait_cnt_d = '0;
                end
                // A single-grant burst limit means the lock can never extend ownership.
                if (dev_gnt && dev_lock && BURST_MAX_C > 4'd1) begin
                    state_d     = S_dev_burst;
                    burst_cnt_d = 4'd1;
                end
            end
            S_dev_burst: begin
                dev_gnt    = dev_req;
                wait_cnt_d = '0;
                if (dev_gnt) begin
                    burst_cnt_d = sat_inc(burst_cnt_q, CNT_SAT);
                end
                if (!dev_lock || !dev_req || burst_cnt_d >= BURST_MAX_C) begin
                    state_d     = S_cpu;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = S_cpu;
                wait_cnt_d  = '0;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        RAM_addr = '0;
        RAM_data = '0;
        RAM_wr   = 1'b0;
        rd_owner = OWN_NONE;
        if (cpu_gnt) begin
            RAM_addr = cpu_addr;
            RAM_data = cpu_wdata;
            RAM_wr   = cpu_wr;
            rd_owner = cpu_wr ? OWN_NONE : OWN_CPU;
        end else if (dev_gnt) begin
            RAM_addr = dev_addr;
            RAM_data = dev_wdata;
            RAM_wr   = dev_wr;
            rd_owner = dev_wr ? OWN_NONE : OWN_DEV;
        end
    end

    always_ff @(negedge CORE_CLK) begin
        if (RESET) begin
            state_q     <= S_cpu;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    dcpu_ram_rdreturn #(
        .DATA_W(DATA_W)
    ) u_rdreturn (
        .clk         (CORE_CLK),
        .srst        (RESET),
        .rd_owner_i  (rd_owner),
        .ram_q_i     (RAM_q),
        .cpu_rvalid_o(cpu_rvalid),
        .cpu_rdata_o (cpu_rdata),
        .dev_rvalid_o(dev_rvalid),
        .dev_rdata_o (dev_rdata)
    );

endmodule

// File: tb/tb_dcpu_ram_arbiter.sv
// Directed bench for dcpu_ram_arbiter with a posedge-clocked RAM model.
module tb_dcpu_ram_arbiter;

    logic        CORE_CLK = 1'b0;
    logic        RESET;
    logic        cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dev_req, dev_wr, dev_lock, dev_gnt, dev_rvalid;
    logic [15:0] dev_addr, dev_wdata, dev_rdata;
    logic [15:0] RAM_addr, RAM_data, RAM_q;
    logic        RAM_wr;

    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_err    = 0;

    always #5 CORE_CLK = ~CORE_CLK;

    dcpu_ram_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MAX_WAIT(4), .BURST_MAX(8)
    ) dut (
        .CORE_CLK  (CORE_CLK),
        .RESET     (RESET),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wr    (cpu_wr),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .dev_req   (dev_req),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_wr    (dev_wr),
        .dev_lock  (dev_lock),
        .dev_gnt   (dev_gnt),
        .dev_rvalid(dev_rvalid),
        .dev_rdata (dev_rdata),
        .RAM_addr  (RAM_addr),
        .RAM_data  (RAM_data),
        .RAM_wr    (RAM_wr),
        .RAM_q     (RAM_q)
    );

    // RAM model; its contents are preloaded while RESET is high.
    always @(posedge CORE_CLK) begin
        if (RESET) begin
            mem[16'h0010] <= 16'hBEEF;
            mem[16'h0020] <= 16'hCAFE;
            mem[16'h0050] <= 16'h5555;
            mem[16'h0060] <= 16'h6666;
            mem[16'h0100] <= 16'h0000;
        end else if (RAM_wr) begin
            mem[RAM_addr] <= RAM_data;
        end
        RAM_q <= mem[RAM_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("  ok %s = %h", tag, obs);
        end
    endtask

    // One bus cycle: drive just after the falling edge, leave time to settle.
    task automatic cyc(input logic creq, input logic [15:0] caddr, input logic [15:0] cwd,
                       input logic cwr, input logic dreq, input logic [15:0] daddr,
                       input logic [15:0] dwd, input logic dwr, input logic dlock,
                       input logic rst);
        @(negedge CORE_CLK);
        #1;
        cpu_req = creq; cpu_addr = caddr; cpu_wdata = cwd; cpu_wr = cwr;
        dev_req = dreq; dev_addr = daddr; dev_wdata = dwd; dev_wr = dwr;
        dev_lock = dlock; RESET = rst;
        #1;
    endtask

    task automatic idle();
        cyc(0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    endtask

    initial begin
        RESET = 1'b1;
        cpu_req = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wr = 0;
        dev_req = 0; dev_addr = 0; dev_wdata = 0; dev_wr = 0; dev_lock = 0;
        repeat (3) cyc(0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1);

        // Reset state
        idle();
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_dev_gnt", dev_gnt, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_dev_rvalid", dev_rvalid, 0);
        check("rst_ram_wr", RAM_wr, 0);
        check("rst_ram_addr", RAM_addr, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);

        // CPU-only read
        cyc(1, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        check("cpu_rd_gnt", cpu_gnt, 1);
        check("cpu_rd_ram_addr", RAM_addr, 16'h0010);
        check("cpu_rd_ram_wr", RAM_wr, 0);
        idle();
        check("cpu_rd_rvalid", cpu_rvalid, 1);
        check("cpu_rd_rdata", cpu_rdata, 16'hBEEF);
        check("cpu_rd_dev_rvalid", dev_rvalid, 0);
        check("idle_ram_addr", RAM_addr, 0);

        // Contention: CPU 4 cycles, device every 5th
        for (int i = 0; i < 10; i++) begin
            cyc(1, 16'h0010, 16'h0, 0, 1, 16'h0020, 16'h0, 0, 0, 0);
            check($sformatf("cont%0d_cpu_gnt", i), cpu_gnt, (i % 5 != 4));
            check($sformatf("cont%0d_dev_gnt", i), dev_gnt, (i % 5 == 4));
            if (i == 1) check("cont_cpu_rdata", cpu_rdata, 16'hBEEF);
            if (i == 5) begin
                check("cont_dev_rvalid", dev_rvalid, 1);
                check("cont_dev_rdata", dev_rdata, 16'hCAFE);
                check("cont_cpu_rvalid", cpu_rvalid, 0);
            end
        end
        idle();

        // Locked burst: 8 device grants, then the waiting CPU
        for (int i = 0; i < 10; i++) begin
            cyc(i >= 1, 16'h0010, 16'h0, 0, 1, 16'h0020, 16'h0, 0, 1, 0);
            check($sformatf("burst%0d_dev_gnt", i), dev_gnt, (i < 8));
            check($sformatf("burst%0d_cpu_gnt", i), cpu_gnt, (i >= 8));
            if (i == 8) check("burst_dev_rvalid", dev_rvalid, 1);
            if (i == 9) begin
                check("burst_after_cpu_rvalid", cpu_rvalid, 1);
                check("burst_after_dev_rvalid", dev_rvalid, 0);
            end
        end
        idle();

        // dev_lock without dev_req is ignored
        cyc(1, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 0);
        check("lock_noreq_cpu_gnt", cpu_gnt, 1);
        cyc(1, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 0);
        check("lock_noreq_cpu_gnt2", cpu_gnt, 1);
        check("lock_noreq_dev_gnt", dev_gnt, 0);
        idle();

        // Write isolation
        check("wr_idle_ram_wr", RAM_wr, 0);
        cyc(1, 16'h0100, 16'h1234, 1, 1, 16'h0040, 16'h0, 0, 0, 0);
        check("wr_cpu_gnt", cpu_gnt, 1);
        check("wr_dev_gnt", dev_gnt, 0);
        check("wr_ram_wr", RAM_wr, 1);
        check("wr_ram_addr", RAM_addr, 16'h0100);
        check("wr_ram_data", RAM_data, 16'h1234);
        cyc(0, 16'h0, 16'h0, 0, 1, 16'h0100, 16'h0, 0, 0, 0);
        check("wr_dev_rd_gnt", dev_gnt, 1);
        check("wr_no_cpu_rvalid", cpu_rvalid, 0);
        idle();
        check("wr_dev_rvalid", dev_rvalid, 1);
        check("wr_dev_rdata", dev_rdata, 16'h1234);
        idle();

        // Back-to-back owner switch: CPU read, then forced device read
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h0010, 16'h0, 0, 1, 16'h0060, 16'h0, 0, 0, 0);
        end
        cyc(1, 16'h0050, 16'h0, 0, 1, 16'h0060, 16'h0, 0, 0, 0);
        check("b2b_cpu_gnt", cpu_gnt, 1);
        cyc(1, 16'h0050, 16'h0, 0, 1, 16'h0060, 16'h0, 0, 0, 0);
        check("b2b_forced_dev_gnt", dev_gnt, 1);
        check("b2b_forced_cpu_gnt", cpu_gnt, 0);
        check("b2b_cpu_rvalid", cpu_rvalid, 1);
        check("b2b_cpu_rdata", cpu_rdata, 16'h5555);
        idle();
        check("b2b_dev_rvalid", dev_rvalid, 1);
        check("b2b_dev_rdata", dev_rdata, 16'h6666);
        check("b2b_cpu_rvalid_low", cpu_rvalid, 0);
        idle();

        // Reset during the third burst grant
        cyc(0, 16'h0, 16'h0, 0, 1, 16'h0020, 16'h0, 0, 1, 0);
        cyc(0, 16'h0, 16'h0, 0, 1, 16'h0020, 16'h0, 0, 1, 0);
        cyc(0, 16'h0, 16'h0, 0, 1, 16'h0020, 16'h0, 0, 1, 1);
        check("rstb_third_dev_gnt", dev_gnt, 1);
        cyc(1, 16'h0010, 16'h0, 0, 1, 16'h0020, 16'h0, 0, 1, 0);
        check("rstb_cpu_first", cpu_gnt, 1);
        check("rstb_dev_gnt", dev_gnt, 0);
        check("rstb_dev_rvalid", dev_rvalid, 0);
        check("rstb_cpu_rvalid", cpu_rvalid, 0);
        idle();
        check("rstb_cpu_rvalid_after", cpu_rvalid, 1);
        check("rstb_cpu_rdata_after", cpu_rdata, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
